// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM stage / MEM-WB pipeline register slice.
// Holds the FSM state encoding, datapath widths and the default ack timeout.
// Pure declarations: no logic, no latency, no flow control.
package mem_wb_pkg;

  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;
  localparam int CNT_W           = 8;
  localparam int ACK_TIMEOUT_DEF = 255;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Control and data carried from EX/MEM into MEM/WB (load data travels separately)
  typedef struct packed {
    logic              reg_write;
    logic              mem2reg;
    logic [REG_W-1:0]  rd_addr;
    logic [DATA_W-1:0] alu_data;
  } wb_ctl_t;

  // Wait counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with separate load and bubble controls.
// Latency: 1 cycle from inputs to outputs.
// Backpressure: none; bubble wins over load, and clears only the write-back controls.
module mem_wb_reg
  import mem_wb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic              i_load_mem,
  input  wb_ctl_t           i_ctl,
  input  logic [DATA_W-1:0] i_mem_data,
  output wb_ctl_t           o_ctl,
  output logic [DATA_W-1:0] o_mem_data
);

  wb_ctl_t           r_ctl;
  logic [DATA_W-1:0] r_mem_data;

  // Capture EX/MEM controls, or neutralise write-back so the slot becomes a no-op
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctl <= '0;
    end else if (i_bubble) begin
      r_ctl.reg_write <= 1'b0;
      r_ctl.mem2reg   <= 1'b0;
    end else if (i_load) begin
      r_ctl <= i_ctl;
    end
  end

  // Load data only changes when a read completes; otherwise it keeps its last value
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_data <= '0;
    end else if (i_load && !i_bubble && i_load_mem) begin
      r_mem_data <= i_mem_data;
    end
  end

  assign o_ctl      = r_ctl;
  assign o_mem_data = r_mem_data;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: issues data-memory requests, stalls upstream until ack or timeout, feeds MEM/WB.
// Latency: 1 cycle for non-memory ops, at least 2 cycles for loads/stores.
// Backpressure: stall_o holds upstream while a request is outstanding. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  input  logic              Mem2Reg_i,
  input  logic [DATA_W-1:0] ALU_data_i,
  input  logic [DATA_W-1:0] writeData_i,
  input  logic [REG_W-1:0]  RDaddr_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic              Mem2Reg_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic [DATA_W-1:0] ALU_data_o,
  output logic [REG_W-1:0]  RDaddr_o,
  output logic              bus_err_o
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_mem_op;
  logic              w_is_read;
  logic              w_misalign;
  logic              w_stall;
  logic              w_load;
  logic              w_bubble;
  logic              w_load_mem;
  logic              w_err;
  logic              w_issue;
  logic              w_done;
  wb_ctl_t           w_ctl_in;
  wb_ctl_t           w_ctl_out;

  assign w_mem_op  = MemRead_i | MemWrite_i;
  // A simultaneous read+write request is performed as a write, so no load data returns
  assign w_is_read = MemRead_i & ~MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (ALU_data_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_ctl_in.reg_write = RegWrite_i;
  assign w_ctl_in.mem2reg   = Mem2Reg_i;
  assign w_ctl_in.rd_addr   = RDaddr_i;
  assign w_ctl_in.alu_data  = ALU_data_i;

  // Next-state and per-cycle control: stall, MEM/WB load/bubble, request issue/retire, error
  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_load     = 1'b0;
    w_bubble   = 1'b0;
    w_load_mem = 1'b0;
    w_err      = 1'b0;
    w_issue    = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_mem_op) begin
          w_load = 1'b1;
        end else if (w_misalign) begin
          // Misaligned access is dropped on the spot; upstream moves on
          w_err    = 1'b1;
          w_bubble = 1'b1;
        end else begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          w_issue  = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack_i) begin
          // Ack beats timeout when both land in the same cycle
          w_load     = 1'b1;
          w_load_mem = w_is_read;
          w_done     = 1'b1;
          w_next     = IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_err    = 1'b1;
          w_bubble = 1'b1;
          w_done   = 1'b1;
          w_next   = IDLE;
        end else begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register and wait counter; counter restarts on every entry to WAIT
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  // Memory request fields are latched at issue and held stable until ack or abort
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_issue) begin
      r_req   <= 1'b1;
      r_we    <= MemWrite_i;
      r_addr  <= ALU_data_i;
      r_wdata <= writeData_i;
    end else if (w_done) begin
      r_req <= 1'b0;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_load),
    .i_bubble   (w_bubble),
    .i_load_mem (w_load_mem),
    .i_ctl      (w_ctl_in),
    .i_mem_data (dmem_rdata_i),
    .o_ctl      (w_ctl_out),
    .o_mem_data (MemData_o)
  );

  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign stall_o      = w_stall;
  // Error pulse is forced low while reset is asserted, even if a misaligned op is presented
  assign bus_err_o    = w_err & rst_i;

  assign RegWrite_o = w_ctl_out.reg_write;
  assign Mem2Reg_o  = w_ctl_out.mem2reg;
  assign RDaddr_o   = w_ctl_out.rd_addr;
  assign ALU_data_o = w_ctl_out.alu_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage built with a 4-cycle ack timeout.
// Inputs change 2 time units after a rising edge; outputs are checked 1 unit after that.
// Expected values are hand-derived constants for each step.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i;
  logic [31:0] ALU_data_i, writeData_i;
  logic [4:0]  RDaddr_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        RegWrite_o, Mem2Reg_o;
  logic [31:0] MemData_o, ALU_data_o;
  logic [4:0]  RDaddr_o;
  logic        bus_err_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  mem_wb_stage #(.ACK_TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .RegWrite_i   (RegWrite_i),
    .MemWrite_i   (MemWrite_i),
    .MemRead_i    (MemRead_i),
    .Mem2Reg_i    (Mem2Reg_i),
    .ALU_data_i   (ALU_data_i),
    .writeData_i  (writeData_i),
    .RDaddr_i     (RDaddr_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .RegWrite_o   (RegWrite_o),
    .Mem2Reg_o    (Mem2Reg_o),
    .MemData_o    (MemData_o),
    .ALU_data_o   (ALU_data_o),
    .RDaddr_o     (RDaddr_o),
    .bus_err_o    (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input logic rw, input logic mw, input logic mr, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    RegWrite_i  = rw;
    MemWrite_i  = mw;
    MemRead_i   = mr;
    Mem2Reg_i   = m2r;
    ALU_data_i  = alu;
    writeData_i = wd;
    RDaddr_i    = rd;
  endtask

  initial begin
    rst_i        = 1'b0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    // Reset state
    chk("rst_req",      {31'd0, dmem_req_o},   32'd0);
    chk("rst_we",       {31'd0, dmem_we_o},    32'd0);
    chk("rst_addr",     dmem_addr_o,           32'd0);
    chk("rst_regwrite", {31'd0, RegWrite_o},   32'd0);
    chk("rst_memdata",  MemData_o,             32'd0);
    chk("rst_stall",    {31'd0, stall_o},      32'd0);
    chk("rst_buserr",   {31'd0, bus_err_o},    32'd0);
    // Memory op present during reset raises stall combinationally
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd0);
    #1;
    chk("rst_stall_memop", {31'd0, stall_o}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    rst_i = 1'b1;
    tick();

    // Plain ALU op: one-cycle pass-through, no stall
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
    #1;
    chk("alu_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("alu_regwrite", {31'd0, RegWrite_o}, 32'd1);
    chk("alu_data",     ALU_data_o,          32'h1234);
    chk("alu_rd",       {27'd0, RDaddr_o},   32'd5);
    chk("alu_stall2",   {31'd0, stall_o},    32'd0);

    // Load at 0x40, ack in the 4th WAIT cycle (which is also the timeout cycle)
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7);
    #1;
    chk("ld_idle_stall", {31'd0, stall_o},    32'd1);
    chk("ld_idle_req",   {31'd0, dmem_req_o}, 32'd0);
    tick();
    chk("ld_w0_stall", {31'd0, stall_o},    32'd1);
    chk("ld_w0_req",   {31'd1 & 32'd0, dmem_req_o}, 32'd1);
    chk("ld_w0_addr",  dmem_addr_o,         32'h40);
    chk("ld_w0_we",    {31'd0, dmem_we_o},  32'd0);
    chk("ld_w0_bub",   {31'd0, RegWrite_o}, 32'd0);
    tick();
    chk("ld_w1_stall", {31'd0, stall_o},    32'd1);
    chk("ld_w1_bub",   {31'd0, RegWrite_o}, 32'd0);
    tick();
    chk("ld_w2_stall", {31'd0, stall_o},    32'd1);
    tick();
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("ld_ack_stall",  {31'd0, stall_o},   32'd0);
    chk("ld_ack_buserr", {31'd0, bus_err_o}, 32'd0);
    tick();
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("ld_memdata",  MemData_o,            32'hDEADBEEF);
    chk("ld_mem2reg",  {31'd0, Mem2Reg_o},   32'd1);
    chk("ld_regwrite", {31'd0, RegWrite_o},  32'd1);
    chk("ld_rd",       {27'd0, RDaddr_o},    32'd7);
    chk("ld_req_clr",  {31'd0, dmem_req_o},  32'd0);
    chk("ld_stall_end",{31'd0, stall_o},     32'd0);
    tick();

    // Store at 0x80, ack in the first WAIT cycle
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'hA5A5A5A5, 5'd0);
    tick();
    chk("st_req",   {31'd0, dmem_req_o}, 32'd1);
    chk("st_we",    {31'd0, dmem_we_o},  32'd1);
    chk("st_addr",  dmem_addr_o,         32'h80);
    chk("st_wdata", dmem_wdata_o,        32'hA5A5A5A5);
    dmem_ack_i = 1'b1;
    #1;
    chk("st_ack_stall", {31'd0, stall_o}, 32'd0);
    chk("st_ack_wdata", dmem_wdata_o,     32'hA5A5A5A5);
    tick();
    dmem_ack_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("st_regwrite", {31'd0, RegWrite_o}, 32'd0);
    chk("st_req_clr",  {31'd0, dmem_req_o}, 32'd0);
    chk("st_memdata",  MemData_o,           32'hDEADBEEF);
    tick();

    // Read and write together behave as a write: load data must not change
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h90, 32'h11112222, 5'd9);
    tick();
    chk("rw_we", {31'd0, dmem_we_o}, 32'd1);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h33334444;
    tick();
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("rw_memdata", MemData_o, 32'hDEADBEEF);
    tick();

    // Timeout: no ack, error pulse in 4th WAIT cycle
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3);
    tick();
    tick();
    tick();
    chk("to_w2_stall",  {31'd0, stall_o},   32'd1);
    chk("to_w2_buserr", {31'd0, bus_err_o}, 32'd0);
    tick();
    chk("to_w3_buserr", {31'd0, bus_err_o}, 32'd1);
    chk("to_w3_stall",  {31'd0, stall_o},   32'd0);
    chk("to_w3_req",    {31'd0, dmem_req_o},32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("to_req_clr",  {31'd0, dmem_req_o}, 32'd0);
    chk("to_buserr0",  {31'd0, bus_err_o},  32'd0);
    chk("to_bubble",   {31'd0, RegWrite_o}, 32'd0);
    chk("to_stall0",   {31'd0, stall_o},    32'd0);

    // Ack while idle is ignored
    dmem_ack_i = 1'b1;
    tick();
    chk("idle_ack_req", {31'd0, dmem_req_o}, 32'd0);
    dmem_ack_i = 1'b0;

    // Preload MEM/WB with non-zero values, then reset in the 2nd WAIT cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 5'd4);
    tick();
    tick();
    chk("rw2_req_pre", {31'd0, dmem_req_o}, 32'd1);
    chk("rw2_alu_pre", ALU_data_o,          32'h55);
    rst_i = 1'b0;
    #1;
    chk("rw2_req",     {31'd0, dmem_req_o}, 32'd0);
    chk("rw2_addr",    dmem_addr_o,         32'd0);
    chk("rw2_alu",     ALU_data_o,          32'd0);
    chk("rw2_memdata", MemData_o,           32'd0);
    chk("rw2_rd",      {27'd0, RDaddr_o},   32'd0);
    chk("rw2_buserr",  {31'd0, bus_err_o},  32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    rst_i = 1'b1;
    tick();
    chk("rw2_post_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("rw2_post_stall", {31'd0, stall_o},    32'd0);

    // Misaligned load at 0x42
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0, 5'd6);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_stall",  {31'd0, stall_o},   32'd0);
    chk("mis_buserr", {31'd0, bus_err_o}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("mis_req",     {31'd0, dmem_req_o}, 32'd0);
    chk("mis_buserr0", {31'd0, bus_err_o},  32'd0);
    chk("mis_bubble",  {31'd0, RegWrite_o}, 32'd0);
`else
    chk("mis_stall",  {31'd0, stall_o},   32'd1);
    chk("mis_buserr", {31'd0, bus_err_o}, 32'd0);
    tick();
    chk("mis_req",  {31'd0, dmem_req_o}, 32'd1);
    chk("mis_addr", dmem_addr_o,         32'h42);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h0BADF00D;
    tick();
    dmem_ack_i   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("mis_memdata", MemData_o, 32'h0BADF00D);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
